// File: rtl/chan_trig_unit_if.sv
// Signal bundle between the capture controller/front-end and the channel-trigger stage.
// The slave side is the trigger unit; the master side drives comparators, config and control.
interface chan_trig_unit_if #(
  parameter int NUM_CH = 5
);
  logic [NUM_CH-1:0]   ch_l;
  logic [NUM_CH-1:0]   ch_h;
  logic [5*NUM_CH-1:0] trig_cfg;
  logic                protTrig;
  logic                armed;
  logic                set_capture_done;
  logic [NUM_CH-1:0]   ch_trig;
  logic                triggered;

  modport master (
    output ch_l, ch_h, trig_cfg, protTrig, armed, set_capture_done,
    input  ch_trig, triggered
  );

  modport slave (
    input  ch_l, ch_h, trig_cfg, protTrig, armed, set_capture_done,
    output ch_trig, triggered
  );
endinterface

// File: rtl/chan_trig_unit.sv
// Channel-trigger stage: synchronises comparator pairs, evaluates per-channel
// level/edge conditions and holds a sticky overall trigger until capture is done.
module chan_trig_unit #(
  parameter int NUM_CH      = 5,
  parameter int SYNC_STAGES = 2   // at least 2 for metastability settling
) (
  input logic              clk,
  input logic              rst_n,
  chan_trig_unit_if.slave  bus
);

  logic [NUM_CH-1:0] l_sync [SYNC_STAGES];
  logic [NUM_CH-1:0] h_sync [SYNC_STAGES];
  logic [NUM_CH-1:0] l_s, h_s, l_d, h_d;
  logic [NUM_CH-1:0] neg_l, pos_h, neg_armed, pos_armed;
  logic [NUM_CH-1:0] neg_seen, pos_seen;
  logic [NUM_CH-1:0] term;
  logic              trig_set;

  // NOTE: every synchroniser stage is cleared as well, so no stale comparator
  // level can fake an edge right after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        l_sync[s] <= '0;
        h_sync[s] <= '0;
      end
      l_d <= '0;
      h_d <= '0;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous
      // stage's old value, which is what turns this loop into a shift chain.
      l_sync[0] <= bus.ch_l;
      h_sync[0] <= bus.ch_h;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        l_sync[s] <= l_sync[s-1];
        h_sync[s] <= h_sync[s-1];
      end
      l_d <= l_s;
      h_d <= h_s;
    end
  end

  assign l_s       = l_sync[SYNC_STAGES-1];
  assign h_s       = h_sync[SYNC_STAGES-1];
  assign neg_l     = l_d & ~l_s;
  assign pos_h     = ~h_d & h_s;
  assign neg_armed = {NUM_CH{bus.armed}} & neg_l;
  assign pos_armed = {NUM_CH{bus.armed}} & pos_h;

  // Disarming clears the latches and wins over an edge arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || !bus.armed) begin
      neg_seen <= '0;
      pos_seen <= '0;
    end else begin
      neg_seen <= neg_seen | neg_armed;
      pos_seen <= pos_seen | pos_armed;
    end
  end

  always_comb begin
    // NOTE: default first so no path through the loop can leave term unassigned.
    term = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      term[i] = bus.trig_cfg[5*i]
              | (bus.trig_cfg[5*i+1] & ~l_s[i])
              | (bus.trig_cfg[5*i+2] &  h_s[i])
              | (bus.trig_cfg[5*i+3] & (neg_seen[i] | neg_armed[i]))
              | (bus.trig_cfg[5*i+4] & (pos_seen[i] | pos_armed[i]));
    end
  end

  assign trig_set = bus.armed & bus.protTrig & (&bus.ch_trig);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.ch_trig   <= '0;
      bus.triggered <= 1'b0;
    end else begin
      bus.ch_trig <= term;
      if (bus.set_capture_done)
        bus.triggered <= 1'b0;
      else if (trig_set)
        bus.triggered <= 1'b1;
    end
  end

endmodule

// File: tb/tb_chan_trig_unit.sv
// Scoreboard bench for chan_trig_unit: tasks push expectations tagged with a cycle,
// samples are recorded every cycle, and each task drains and compares its own entries.
module tb_chan_trig_unit;

  typedef struct {
    int         cyc;
    logic [4:0] ch;
    logic [4:0] mask;
    logic       tvld;
    logic       trig;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb [$];
  logic [5:0] obs [int];

  chan_trig_unit_if #(.NUM_CH(5)) bus ();

  chan_trig_unit #(.NUM_CH(5), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      obs[cyc] = {bus.triggered, bus.ch_trig};
    end
  endtask

  task automatic expect_after(input int k, input logic [4:0] ch, input logic [4:0] mask,
                              input logic tvld, input logic trig, input string name);
    exp_t e;
    e.cyc = cyc + k; e.ch = ch; e.mask = mask; e.tvld = tvld; e.trig = trig; e.name = name;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e; logic [5:0] o;
    rst_n = 1'b0; bus.armed = 1'b0; bus.protTrig = 1'b1; bus.set_capture_done = 1'b0;
    bus.ch_l = '0; bus.ch_h = '0; bus.trig_cfg = {5{5'h01}};
    expect_after(1, 5'h00, 5'h1F, 1'b1, 1'b0, "reset_state");
    tick(1);
    rst_n = 1'b1;
    expect_after(1, 5'h1F, 5'h1F, 1'b1, 1'b0, "dontcare_1cycle");
    expect_after(3, 5'h1F, 5'h1F, 1'b1, 1'b0, "disarmed_no_trig");
    tick(3);
    bus.armed = 1'b1;
    expect_after(1, 5'h1F, 5'h1F, 1'b1, 1'b1, "arm_trig_1cycle");
    tick(1);
    bus.armed = 1'b0; bus.protTrig = 1'b0;
    expect_after(20, 5'h00, 5'h00, 1'b1, 1'b1, "trig_hold_20");
    tick(20);
    bus.set_capture_done = 1'b1;
    expect_after(1, 5'h00, 5'h00, 1'b1, 1'b0, "capture_done_clear");
    tick(1);
    bus.set_capture_done = 1'b0;
    expect_after(2, 5'h00, 5'h00, 1'b1, 1'b0, "stays_clear");
    tick(2);
    while (sb.size() != 0) begin
      e = sb.pop_front(); n_cmp++;
      if (!obs.exists(e.cyc)) begin n_err++; $display("FAIL %s: no sample at cycle %0d", e.name, e.cyc); end
      else begin
        o = obs[e.cyc];
        if ((o[4:0] & e.mask) !== (e.ch & e.mask) || (e.tvld && o[5] !== e.trig)) begin
          n_err++;
          $display("FAIL %s: ch_trig=%b triggered=%b, expected ch_trig=%b (mask %b) triggered=%b",
                   e.name, o[4:0], o[5], e.ch, e.mask, e.trig);
        end
      end
    end
  endtask

  task automatic test_low_level();
    exp_t e; logic [5:0] o;
    bus.armed = 1'b0; bus.protTrig = 1'b1;
    bus.trig_cfg = {5'h01, 5'h01, 5'h01, 5'h01, 5'h02};
    bus.ch_l = 5'h01; bus.ch_h = '0;
    tick(4);
    bus.armed = 1'b1;
    expect_after(5, 5'h1E, 5'h1F, 1'b1, 1'b0, "low_level_blocked");
    tick(5);
    bus.ch_l = 5'h00;
    expect_after(2, 5'h1E, 5'h1F, 1'b1, 1'b0, "low_latency_n1");
    expect_after(3, 5'h1F, 5'h1F, 1'b1, 1'b0, "low_latency_n2");
    expect_after(4, 5'h1F, 5'h1F, 1'b1, 1'b1, "trig_latency_n3");
    tick(4);
    bus.armed = 1'b0; bus.protTrig = 1'b0; bus.set_capture_done = 1'b1;
    tick(1);
    bus.set_capture_done = 1'b0;
    tick(1);
    while (sb.size() != 0) begin
      e = sb.pop_front(); n_cmp++;
      if (!obs.exists(e.cyc)) begin n_err++; $display("FAIL %s: no sample at cycle %0d", e.name, e.cyc); end
      else begin
        o = obs[e.cyc];
        if ((o[4:0] & e.mask) !== (e.ch & e.mask) || (e.tvld && o[5] !== e.trig)) begin
          n_err++;
          $display("FAIL %s: ch_trig=%b triggered=%b, expected ch_trig=%b (mask %b) triggered=%b",
                   e.name, o[4:0], o[5], e.ch, e.mask, e.trig);
        end
      end
    end
  endtask

  task automatic test_posedge();
    exp_t e; logic [5:0] o;
    bus.armed = 1'b0; bus.protTrig = 1'b0; bus.ch_l = '0; bus.ch_h = '0;
    bus.trig_cfg = {5'h01, 5'h01, 5'h10, 5'h01, 5'h01};
    tick(3);
    bus.armed = 1'b1;
    expect_after(3, 5'h1B, 5'h1F, 1'b1, 1'b0, "pos_idle");
    tick(3);
    bus.ch_h = 5'h04;
    expect_after(2, 5'h1B, 5'h1F, 1'b1, 1'b0, "pos_wait");
    expect_after(3, 5'h1F, 5'h1F, 1'b1, 1'b0, "pos_rise");
    tick(4);
    bus.ch_h = 5'h00;
    expect_after(6, 5'h1F, 5'h1F, 1'b1, 1'b0, "pos_sticky");
    tick(6);
    bus.armed = 1'b0;
    expect_after(2, 5'h1B, 5'h1F, 1'b1, 1'b0, "disarm_clear");
    tick(2);
    while (sb.size() != 0) begin
      e = sb.pop_front(); n_cmp++;
      if (!obs.exists(e.cyc)) begin n_err++; $display("FAIL %s: no sample at cycle %0d", e.name, e.cyc); end
      else begin
        o = obs[e.cyc];
        if ((o[4:0] & e.mask) !== (e.ch & e.mask) || (e.tvld && o[5] !== e.trig)) begin
          n_err++;
          $display("FAIL %s: ch_trig=%b triggered=%b, expected ch_trig=%b (mask %b) triggered=%b",
                   e.name, o[4:0], o[5], e.ch, e.mask, e.trig);
        end
      end
    end
  endtask

  task automatic test_negedge_armed();
    exp_t e; logic [5:0] o;
    bus.armed = 1'b0; bus.protTrig = 1'b0; bus.ch_h = '0;
    bus.trig_cfg = {5'h08, 5'h01, 5'h01, 5'h01, 5'h01};
    bus.ch_l = 5'h10;
    tick(4);
    bus.ch_l = 5'h00;
    tick(5);
    bus.armed = 1'b1;
    expect_after(3, 5'h0F, 5'h1F, 1'b1, 1'b0, "neg_while_disarmed");
    tick(3);
    bus.ch_l = 5'h10;
    expect_after(4, 5'h0F, 5'h1F, 1'b1, 1'b0, "neg_rise_ignored");
    tick(4);
    bus.ch_l = 5'h00;
    expect_after(2, 5'h0F, 5'h1F, 1'b1, 1'b0, "neg_wait");
    expect_after(3, 5'h1F, 5'h1F, 1'b1, 1'b0, "neg_armed");
    expect_after(7, 5'h1F, 5'h1F, 1'b1, 1'b0, "neg_sticky");
    tick(7);
    bus.armed = 1'b0;
    tick(2);
    while (sb.size() != 0) begin
      e = sb.pop_front(); n_cmp++;
      if (!obs.exists(e.cyc)) begin n_err++; $display("FAIL %s: no sample at cycle %0d", e.name, e.cyc); end
      else begin
        o = obs[e.cyc];
        if ((o[4:0] & e.mask) !== (e.ch & e.mask) || (e.tvld && o[5] !== e.trig)) begin
          n_err++;
          $display("FAIL %s: ch_trig=%b triggered=%b, expected ch_trig=%b (mask %b) triggered=%b",
                   e.name, o[4:0], o[5], e.ch, e.mask, e.trig);
        end
      end
    end
  endtask

  task automatic test_prot_priority();
    exp_t e; logic [5:0] o;
    bus.trig_cfg = {5{5'h01}}; bus.ch_l = '0; bus.ch_h = '0;
    bus.armed = 1'b1; bus.protTrig = 1'b0;
    expect_after(3, 5'h1F, 5'h1F, 1'b1, 1'b0, "prot_low_blocks");
    tick(3);
    bus.protTrig = 1'b1; bus.set_capture_done = 1'b1;
    expect_after(1, 5'h1F, 5'h1F, 1'b1, 1'b0, "done_beats_set");
    tick(1);
    bus.set_capture_done = 1'b0;
    expect_after(1, 5'h1F, 5'h1F, 1'b1, 1'b1, "set_after_done");
    tick(1);
    bus.armed = 1'b0; bus.protTrig = 1'b0; bus.trig_cfg = '0;
    expect_after(3, 5'h00, 5'h1F, 1'b1, 1'b1, "sticky_trig_cfg0");
    tick(3);
    bus.set_capture_done = 1'b1;
    expect_after(1, 5'h00, 5'h1F, 1'b1, 1'b0, "done_clear");
    tick(1);
    bus.set_capture_done = 1'b0;
    while (sb.size() != 0) begin
      e = sb.pop_front(); n_cmp++;
      if (!obs.exists(e.cyc)) begin n_err++; $display("FAIL %s: no sample at cycle %0d", e.name, e.cyc); end
      else begin
        o = obs[e.cyc];
        if ((o[4:0] & e.mask) !== (e.ch & e.mask) || (e.tvld && o[5] !== e.trig)) begin
          n_err++;
          $display("FAIL %s: ch_trig=%b triggered=%b, expected ch_trig=%b (mask %b) triggered=%b",
                   e.name, o[4:0], o[5], e.ch, e.mask, e.trig);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; logic [5:0] o;
    bus.trig_cfg = {5{5'h08}}; bus.armed = 1'b0; bus.protTrig = 1'b1;
    bus.ch_l = 5'h1F; bus.ch_h = '0;
    tick(4);
    bus.armed = 1'b1; bus.ch_l = 5'h00;
    expect_after(3, 5'h1F, 5'h1F, 1'b1, 1'b0, "neg_all");
    expect_after(4, 5'h1F, 5'h1F, 1'b1, 1'b1, "neg_all_trig");
    tick(5);
    rst_n = 1'b0;
    expect_after(1, 5'h00, 5'h1F, 1'b1, 1'b0, "reset_mid");
    tick(1);
    rst_n = 1'b1;
    expect_after(2, 5'h00, 5'h1F, 1'b1, 1'b0, "latches_cleared_a");
    expect_after(4, 5'h00, 5'h1F, 1'b1, 1'b0, "latches_cleared_b");
    tick(4);
    bus.armed = 1'b0; bus.protTrig = 1'b0;
    tick(1);
    while (sb.size() != 0) begin
      e = sb.pop_front(); n_cmp++;
      if (!obs.exists(e.cyc)) begin n_err++; $display("FAIL %s: no sample at cycle %0d", e.name, e.cyc); end
      else begin
        o = obs[e.cyc];
        if ((o[4:0] & e.mask) !== (e.ch & e.mask) || (e.tvld && o[5] !== e.trig)) begin
          n_err++;
          $display("FAIL %s: ch_trig=%b triggered=%b, expected ch_trig=%b (mask %b) triggered=%b",
                   e.name, o[4:0], o[5], e.ch, e.mask, e.trig);
        end
      end
    end
  endtask

  task automatic test_cfg_sweep();
    exp_t e; logic [5:0] o;
    logic [4:0] cv;
    logic l, h, bit_exp;
    bus.armed = 1'b0; bus.protTrig = 1'b0;
    for (int combo = 0; combo < 4; combo++) begin
      l = combo[0]; h = combo[1];
      bus.ch_l = {3'b000, l, 1'b0};
      bus.ch_h = {3'b000, h, 1'b0};
      tick(3);
      for (int c = 0; c < 32; c++) begin
        cv = c[4:0];
        bus.trig_cfg = {5'h01, 5'h01, 5'h01, cv, 5'h01};
        // Disarmed: edge terms are zero, only don't-care and level terms count.
        bit_exp = cv[0] | (cv[1] & ~l) | (cv[2] & h);
        expect_after(1, {3'b111, bit_exp, 1'b1}, 5'h1F, 1'b1, 1'b0,
                     $sformatf("cfg_sweep cfg=%h l=%b h=%b", cv, l, h));
        tick(1);
      end
    end
    while (sb.size() != 0) begin
      e = sb.pop_front(); n_cmp++;
      if (!obs.exists(e.cyc)) begin n_err++; $display("FAIL %s: no sample at cycle %0d", e.name, e.cyc); end
      else begin
        o = obs[e.cyc];
        if ((o[4:0] & e.mask) !== (e.ch & e.mask) || (e.tvld && o[5] !== e.trig)) begin
          n_err++;
          $display("FAIL %s: ch_trig=%b triggered=%b, expected ch_trig=%b (mask %b) triggered=%b",
                   e.name, o[4:0], o[5], e.ch, e.mask, e.trig);
        end
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_low_level();
    test_posedge();
    test_negedge_armed();
    test_prot_priority();
    test_reset_mid();
    test_cfg_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/chan_trig_unit.md
Name: chan_trig_unit

Overview:
- Channel-trigger stage of the logic analyser.
- Synchronizes the five comparator pairs (CHxL/CHxH) into the capture clock domain, and evaluates each channel against its 5-bit CHxTrigCfg (don't-care, low level, high level, negedge, posedge) to produce the per-channel CHxTrig flags.
- Combines those flags with protTrig and armed into a latched triggered flag consumed by the capture controller; the flag is released by set_capture_done.

Parameters:
NUM_CH, 5, number of analog channels (each has an L and an H comparator output)
SYNC_STAGES, 2, metastability flops per comparator input (minimum 2)

Ports:
clk  in  1  capture clock
rst_n  in  1  reset, synchronous, active-low
ch_l  in  NUM_CH  asynchronous low-threshold comparator outputs, bit i = CH(i+1)L
ch_h  in  NUM_CH  asynchronous high-threshold comparator outputs, bit i = CH(i+1)H
trig_cfg  in  5*NUM_CH  per-channel config; bits [5i+4:5i] = CH(i+1)TrigCfg
protTrig  in  1  protocol (UART/SPI) trigger qualifier from the protocol trigger stage
armed  in  1  capture armed by the capture controller
set_capture_done  in  1  single-cycle pulse; capture finished
ch_trig  out  NUM_CH  registered per-channel trigger flags (CHxTrig)
triggered  out  1  registered, sticky overall trigger

Behaviour:
- Reset: all sync flops, edge-history flops, sticky edge latches, ch_trig and triggered clear to 0 on the clk edge where rst_n=0. Reset mid-capture drops triggered the following cycle.
- Sync: ch_l/ch_h each pass through SYNC_STAGES flops, giving l_s/h_s. One further flop gives l_d/h_d for edge detection.
- Edge detection:
  - neg_l = l_d & ~l_s (falling CHxL).
  - pos_h = ~l... correction: pos_h = ~h_d & h_s (rising CHxH).
  - Edges count only while armed=1, so power-up transitions from the 0 reset state are ignored unless already armed.
- Sticky edge latches, per channel:
  - neg_seen sets when armed & neg_l; pos_seen sets when armed & pos_h.
  - Both clear on any cycle with armed=0; the clear wins over a simultaneous set.
- Per-channel term, with cfg = that channel's 5 config bits; registered into ch_trig[i] each cycle:
  - cfg[0]: don't care → term = 1.
  - cfg[1] & ~l_s: low level.
  - cfg[2] & h_s: high level.
  - cfg[3] & (neg_seen | (armed & neg_l)): negedge.
  - cfg[4] & (pos_seen | (armed & pos_h)): posedge.
  - ch_trig[i] = OR of the five terms.
  - cfg = 0 → ch_trig[i] = 0 permanently; that channel blocks triggering.
- Latency (SYNC_STAGES=2): a level change on ch_h/ch_l sampled at edge N is reflected in ch_trig after edge N+2, and in triggered after edge N+3.
- triggered:
  - Next-state rule: if set_capture_done → 0; else if triggered → 1; else if armed & protTrig & (&ch_trig) → 1; else 0.
  - set_capture_done has priority over a simultaneous set condition.
  - Once set, triggered holds even if armed, protTrig or ch_trig drop.
- Config changes take effect on ch_trig the cycle after the write. A config change does not clear the sticky latches.
- Purely synchronous design; no combinational path from inputs to outputs.

Test Plan:
- Reset, all cfg=5'h01, protTrig=1, armed=0: ch_trig=5'h1F after 1 cycle, triggered stays 0. Raise armed: triggered=1 exactly 1 cycle later; hold 20 cycles; pulse set_capture_done → triggered=0 next cycle.
- CH1 cfg=5'h02, others 5'h01, armed=1, protTrig=1, ch_l[0]=1: triggered stays 0. Drive ch_l[0]=0 at edge N → ch_trig[0]=1 after N+2, triggered=1 after N+3.
- CH3 cfg=5'h10, armed=1: pulse ch_h[2] 0→1→0 (high for 4 cycles) → ch_trig[2] rises and stays 1 after ch_h[2] returns low. Drop armed → ch_trig[2]=0 within 2 cycles.
- CH5 cfg=5'h08, armed=0: toggle ch_l[4] 1→0, then set armed → ch_trig[4]=0, because an edge seen while disarmed is ignored. Repeat with armed=1 → ch_trig[4]=1.
- All cfg=5'h01, armed=1, protTrig=0 → triggered=0. Assert protTrig together with set_capture_done in the same cycle → triggered=0 that cycle, then 1 the next cycle after set_capture_done drops.
- Assert rst_n=0 for 1 cycle while triggered=1 and sticky latches are set → triggered, ch_trig and latches all 0. Sweep cfg 0..31 on CH2 with all 4 comparator-state combinations and compare ch_trig[1] against the OR-of-terms model.
